// File: rtl/dbg_bram_pkg.sv
// Shared types and helpers for the debug-capable word BRAM.
// Optional feature macro used by the top: BRAM_PARITY_EN (per-lane even parity).
package dbg_bram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } clrState_t;

    localparam int NLANES = 4;

    // One even-parity bit per byte lane: the bit makes the lane plus parity hold an even number of ones.
    function automatic logic [NLANES-1:0] byte_parity(input logic [31:0] word);
        logic [NLANES-1:0] p;
        for (int lane = 0; lane < NLANES; lane++) begin
            p[lane] = ^word[8*lane +: 8];
        end
        return p;
    endfunction

    // Byte address to word index; the caller truncates to its own index width, which gives the wrap.
    function automatic logic [29:0] wordIndex(input logic [31:0] byteAddr);
        return byteAddr[31:2];
    endfunction

endpackage

// File: rtl/dbg_bram_clear_fsm.sv
// Zero-fill sweep sequencer: walks every word index once and raises a write strobe per cycle.
module dbg_bram_clear_fsm
    import dbg_bram_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST,
    input  logic              clrReq,
    output logic              clrBusy,
    output logic              clrDone,
    output logic              sweepWe,
    output logic [ADDR_W-1:0] sweepIdx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    clrState_t         state;
    clrState_t         stateNext;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cntNext;

    // State and sweep counter registers; reset drops any sweep in progress.
    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state and strobe decode; requests outside IDLE are deliberately dropped.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        clrBusy   = 1'b0;
        clrDone   = 1'b0;
        sweepWe   = 1'b0;
        sweepIdx  = cnt;
        case (state)
            IDLE: begin
                if (clrReq) begin
                    stateNext = SWEEP;
                    cntNext   = '0;
                end
            end
            SWEEP: begin
                clrBusy = 1'b1;
                sweepWe = 1'b1;
                if (cnt == LAST_IDX) begin
                    stateNext = DONE;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            DONE: begin
                clrDone   = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: rtl/dbg_bram_responder.sv
// Dual-port word BRAM: port 1 serves the CPU, port 2 serves debug load/dump and the zero-fill sweep.
// Optional macro BRAM_PARITY_EN adds per-lane even parity and drives PERR1/PERR2.
module dbg_bram_responder
    import dbg_bram_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST,
    input  logic [31:0]       A1,
    input  logic [DATA_W-1:0] WD1,
    input  logic [NLANES-1:0] WE1,
    output logic [DATA_W-1:0] RD1,
    input  logic [31:0]       A2,
    input  logic [DATA_W-1:0] WD2,
    input  logic [NLANES-1:0] WE2,
    output logic [DATA_W-1:0] RD2,
    input  logic              CLR_REQ,
    output logic              CLR_BUSY,
    output logic              CLR_DONE,
    output logic              PERR1,
    output logic              PERR2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] idx1;
    logic [ADDR_W-1:0] idx2;
    logic              sweepWe;
    logic [ADDR_W-1:0] sweepIdx;
    logic [NLANES-1:0] we2Eff;
    logic [ADDR_W-1:0] idx2W;
    logic [DATA_W-1:0] wd2Eff;

    assign idx1 = ADDR_W'(wordIndex(A1));
    assign idx2 = ADDR_W'(wordIndex(A2));

    dbg_bram_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) uClearFsm (
        .CPU_CLK  (CPU_CLK),
        .CPU_RST  (CPU_RST),
        .clrReq   (CLR_REQ),
        .clrBusy  (CLR_BUSY),
        .clrDone  (CLR_DONE),
        .sweepWe  (sweepWe),
        .sweepIdx (sweepIdx)
    );

    // Port-2 write path: the sweep takes it over and debug writes are suppressed while it runs.
    always_comb begin
        we2Eff = WE2;
        idx2W  = idx2;
        wd2Eff = WD2;
        if (sweepWe) begin
            we2Eff = '1;
            idx2W  = sweepIdx;
            wd2Eff = '0;
        end
    end

    // Array writes; port 2 is applied last so it wins shared lanes (and the sweep beats port 1).
    always_ff @(posedge CPU_CLK) begin
        for (int lane = 0; lane < NLANES; lane++) begin
            if (WE1[lane]) begin
                mem[idx1][8*lane +: 8] <= WD1[8*lane +: 8];
            end
        end
        for (int lane = 0; lane < NLANES; lane++) begin
            if (we2Eff[lane]) begin
                mem[idx2W][8*lane +: 8] <= wd2Eff[8*lane +: 8];
            end
        end
    end

    // Registered read-first reads; the debug port freezes during the sweep.
    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            RD1 <= '0;
            RD2 <= '0;
        end else begin
            RD1 <= mem[idx1];
            if (!CLR_BUSY) begin
                RD2 <= mem[idx2];
            end
        end
    end

`ifdef BRAM_PARITY_EN
    logic [NLANES-1:0] par [DEPTH];
    logic [NLANES-1:0] wp1;
    logic [NLANES-1:0] wp2;

    assign wp1 = byte_parity(WD1);
    assign wp2 = byte_parity(wd2Eff);

    // Parity bits follow their lanes with the same priority as the data; sweep data 0 yields parity 0.
    always_ff @(posedge CPU_CLK) begin
        for (int lane = 0; lane < NLANES; lane++) begin
            if (WE1[lane]) begin
                par[idx1][lane] <= wp1[lane];
            end
        end
        for (int lane = 0; lane < NLANES; lane++) begin
            if (we2Eff[lane]) begin
                par[idx2W][lane] <= wp2[lane];
            end
        end
    end

    // Parity check registered alongside the read data it describes.
    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            PERR1 <= 1'b0;
            PERR2 <= 1'b0;
        end else begin
            PERR1 <= |(byte_parity(mem[idx1]) ^ par[idx1]);
            if (!CLR_BUSY) begin
                PERR2 <= |(byte_parity(mem[idx2]) ^ par[idx2]);
            end
        end
    end
`else
    assign PERR1 = 1'b0;
    assign PERR2 = 1'b0;
`endif

endmodule
